// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one bit per clock through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf_o.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic s_d, carry_d, last_d;

  assign s_d     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_d  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          sum_q   <= {s_d, sum_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB cell.
            ovf_q   <= carry_q ^ carry_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8, 2 and 32.
// Driver pushes expected results; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  start_v, sub_v, busy_v, done_v, cout_v, ovf_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [7:0]  s8;
  logic [1:0]  s2;
  logic [31:0] s32;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .sub_i(sub_v[0]),
    .a_i(a_v[0][7:0]), .b_i(b_v[0][7:0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .sum_o(s8), .cout_o(cout_v[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf_v[0])
`endif
  );
  serial_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .sub_i(sub_v[1]),
    .a_i(a_v[1][1:0]), .b_i(b_v[1][1:0]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .sum_o(s2), .cout_o(cout_v[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf_v[1])
`endif
  );
  serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .sub_i(sub_v[2]),
    .a_i(a_v[2]), .b_i(b_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .sum_o(s32), .cout_o(cout_v[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf_v[2])
`endif
  );
`ifndef SERIAL_ADDER_OVF_EN
  assign ovf_v = '0;
`endif

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int u);
    case (u)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int u);
    case (u)
      0:       return {24'b0, s8};
      1:       return {30'b0, s2};
      default: return s32;
    endcase
  endfunction

  // Reference: full-width add of a and the (possibly inverted) b, then mask.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sb, output logic [31:0] s, output logic c,
                                output logic o);
    logic [63:0] m, bb, t;
    m  = (64'd1 << w) - 64'd1;
    bb = sb ? (~{32'b0, b} & m) : ({32'b0, b} & m);
    t  = ({32'b0, a} & m) + bb + {63'b0, sb};
    s  = t[31:0] & m[31:0];
    c  = t[w];
    o  = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int u, input logic [31:0] es, input logic ec,
                          input logic eo, input int due);
    exp_t t;
    t.id = u; t.s = es; t.c = ec; t.o = eo; t.due = due;
    sb_q.push_back(t);
  endtask

  // Called at a negedge; the start is accepted at the following posedge.
  task automatic issue(input int u, input logic sb, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic ec, input logic eo);
    start_v[u] = 1'b1;
    sub_v[u]   = sb;
    a_v[u]     = a;
    b_v[u]     = b;
    push_exp(u, es, ec, eo, cyc + 1 + wid(u));
  endtask

  task automatic wait_done(input int u);
    for (int n = 0; n < wid(u) + 10; n++) begin
      @(negedge clk);
      if (done_v[u]) break;
    end
    check("done_timeout", {31'b0, done_v[u]}, 32'd1);
  endtask

  task automatic run_op(input int u, input logic sb, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic ec, input logic eo);
    int bc;
    bc = 0;
    issue(u, sb, a, b, es, ec, eo);
    for (int n = 0; n < wid(u) + 10; n++) begin
      @(negedge clk);
      start_v[u] = 1'b0;
      if (busy_v[u]) bc++;
      if (done_v[u]) break;
    end
    check("done_timeout", {31'b0, done_v[u]}, 32'd1);
    check("busy_cycles", bc, wid(u));
    @(negedge clk);
  endtask

  task automatic run_rand(input int u, input logic sb, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] es;
    logic        ec, eo;
    model(wid(u), a, b, sb, es, ec, eo);
    run_op(u, sb, a, b, es, ec, eo);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        if (sb_q.size() == 0) begin
          check("stray_done", {31'b0, done_v[i]}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("result_inst", i, mon_e.id);
          check("sum", sum_of(i), mon_e.s);
          check("cout", {31'b0, cout_v[i]}, {31'b0, mon_e.c});
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", {31'b0, ovf_v[i]}, {31'b0, mon_e.o});
`endif
          check("latency", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_v = '0;
    sub_v   = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", {31'b0, busy_v[i]}, 32'd0);
      check("rst_done", {31'b0, done_v[i]}, 32'd0);
      check("rst_sum", sum_of(i), 32'd0);
      check("rst_cout", {31'b0, cout_v[i]}, 32'd0);
      check("rst_ovf", {31'b0, ovf_v[i]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 vectors.
    run_op(0, 1'b0, 32'h5A, 32'h33, 32'h8D, 1'b0, 1'b1);
    run_op(0, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
    run_op(0, 1'b1, 32'h10, 32'h20, 32'hF0, 1'b0, 1'b0);
    run_op(0, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);

    // Start pulse during RUN with other operands must be ignored.
    issue(0, 1'b0, 32'h12, 32'h34, 32'h46, 1'b0, 1'b0);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; sub_v[0] = 1'b1; a_v[0] = 32'hFF; b_v[0] = 32'hFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    @(negedge clk);

    // Start held through DONE: second op accepted on the edge after done.
    issue(0, 1'b0, 32'h01, 32'h02, 32'h03, 1'b0, 1'b0);
    @(negedge clk);
    a_v[0] = 32'h7F; b_v[0] = 32'h01;
    push_exp(0, 32'h80, 1'b0, 1'b1, sb_q[sb_q.size()-1].due + 9);
    wait_done(0);
    @(negedge clk);
    start_v[0] = 1'b0;
    check("held_busy", {31'b0, busy_v[0]}, 32'd1);
    check("held_done", {31'b0, done_v[0]}, 32'd0);
    wait_done(0);
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    start_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 32'hAA; b_v[0] = 32'h55;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_v[0]}, 32'd0);
    check("abort_done", {31'b0, done_v[0]}, 32'd0);
    check("abort_sum", sum_of(0), 32'd0);
    check("abort_cout", {31'b0, cout_v[0]}, 32'd0);
    check("abort_ovf", {31'b0, ovf_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle", {31'b0, busy_v[0]}, 32'd0);
    run_op(0, 1'b0, 32'hC8, 32'h64, 32'h2C, 1'b1, 1'b0);

    // WIDTH=2 and WIDTH=32: boundary vectors plus random operands via the model.
    run_op(1, 1'b0, 32'h1, 32'h1, 32'h2, 1'b0, 1'b1);
    run_op(1, 1'b1, 32'h0, 32'h1, 32'h3, 1'b0, 1'b0);
    run_op(2, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    run_op(2, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_rand(1, k[0], $urandom, $urandom);
      run_rand(2, k[0], $urandom, $urandom);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
